// File: rtl/flap_input_ctrl.sv
// Flap request front end: PS/2 make/break parser plus debounced pushbutton, merged into one sticky flap flag.
// Latency: a FLAP_CODE strobe in cycle N sets flap_pending in N+1; a button press sets it about DEBOUNCE_CYCLES+3 cycles after the raw edge.
// Backpressure: none. Events that arrive during the holdoff window are dropped, not queued; flap_pending holds until flap_ack.
//
// Ports:
//   clock            system clock
//   reset            asynchronous reset, active high
//   ps2_key_data     received PS/2 byte, qualified by ps2_key_pressed
//   ps2_key_pressed  one-cycle strobe per received byte
//   button_n         raw pushbutton, active low, asynchronous to clock
//   flap_ack         one-cycle pulse: the pending flap has been consumed
//   flap_pending     sticky flap request
//   flap_word        {31'b0, flap_pending}, regfile write data for reg2
//   flap_count       accepted flaps since reset, wraps 255->0
//   key_held         FLAP_CODE currently held down, per make/break tracking
module flap_input_ctrl #(
  parameter logic [7:0] FLAP_CODE       = 8'h29,
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         HOLDOFF_CYCLES  = 2500000,
  parameter int         CNT_W           = 22
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  ps2_key_data,
  input  logic        ps2_key_pressed,
  input  logic        button_n,
  input  logic        flap_ack,
  output logic        flap_pending,
  output logic [31:0] flap_word,
  output logic [7:0]  flap_count,
  output logic        key_held
);

  localparam logic [7:0]       PS2_EXT   = 8'hE0;
  localparam logic [7:0]       PS2_BRK   = 8'hF0;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } ps2_state_t;

  ps2_state_t       r_state;
  ps2_state_t       w_state_nxt;
  logic             w_kev;
  logic             w_held_set;
  logic             w_held_clr;
  logic             r_key_held;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_btn_stable;
  logic [CNT_W-1:0] r_db_cnt;
  logic             r_bev;

  logic             w_accept;
  logic [CNT_W-1:0] r_holdoff;
  logic             r_pending;
  logic [7:0]       r_count;

  // ---------------------------------------------------------------------------
  // PS/2 parser. Only a fresh make of FLAP_CODE from IDLE is a key event;
  // typematic repeats arrive while key_held is already set and are ignored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kev       = 1'b0;
    w_held_set  = 1'b0;
    w_held_clr  = 1'b0;
    if (ps2_key_pressed) begin
      case (r_state)
        S_IDLE: begin
          if (ps2_key_data == PS2_EXT) begin
            w_state_nxt = S_EXT;
          end else if (ps2_key_data == PS2_BRK) begin
            w_state_nxt = S_BRK;
          end else begin
            w_state_nxt = S_IDLE;
            if (ps2_key_data == FLAP_CODE) begin
              w_kev      = ~r_key_held;
              w_held_set = 1'b1;
            end
          end
        end
        // Extended keys share make codes with normal keys; swallow them.
        S_EXT: begin
          w_state_nxt = (ps2_key_data == PS2_BRK) ? S_EXT_BRK : S_IDLE;
        end
        S_BRK: begin
          w_state_nxt = S_IDLE;
          if (ps2_key_data == FLAP_CODE) begin
            w_held_clr = 1'b1;
          end
        end
        S_EXT_BRK: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_key_held <= 1'b0;
    end else if (w_held_set) begin
      r_key_held <= 1'b1;
    end else if (w_held_clr) begin
      r_key_held <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Button: two-flop synchronizer, then a debounce counter that runs only
  // while the synced level disagrees with the stable level. Any bounce back
  // to the stable level restarts the count. A press (stable 1->0) produces a
  // one-cycle event; a release produces nothing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_btn_stable <= 1'b1;
      r_db_cnt     <= '0;
      r_bev        <= 1'b0;
    end else begin
      r_sync1 <= button_n;
      r_sync2 <= r_sync1;
      r_bev   <= 1'b0;
      if (r_sync2 == r_btn_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_btn_stable <= r_sync2;
        r_db_cnt     <= '0;
        r_bev        <= ~r_sync2;
      end else begin
        r_db_cnt <= r_db_cnt + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Merge, rate limit and pending flag. A key and a button event in the same
  // cycle count once. A new accept beats a simultaneous ack so no flap is lost.
  // ---------------------------------------------------------------------------
  assign w_accept = (w_kev | r_bev) & (r_holdoff == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_holdoff <= '0;
      r_count   <= 8'd0;
      r_pending <= 1'b0;
    end else begin
      if (w_accept) begin
        r_holdoff <= HOLD_LOAD;
        r_count   <= r_count + 8'd1;
      end else if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - CNT_ONE;
      end

      if (w_accept) begin
        r_pending <= 1'b1;
      end else if (flap_ack) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign flap_pending = r_pending;
  assign flap_word    = {31'b0, r_pending};
  assign flap_count   = r_count;
  assign key_held     = r_key_held;

endmodule
